// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control decoder plus iterative multiply/divide unit owning HI/LO.
module alu_ctrl_muldiv #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned FUNCT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         alu_op,
   input  logic [FUNCT_W-1:0] funct,
   input  logic               ex_fire,
   input  logic [WIDTH-1:0]   src_a,
   input  logic [WIDTH-1:0]   src_b,
   output logic [3:0]         alu_ctl,
   output logic               md_busy,
   output logic               md_stall,
   output logic               md_sel,
   output logic [WIDTH-1:0]   md_result,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(6'b100000);
   localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'(6'b100010);
   localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'b100100);
   localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(6'b100101);
   localparam logic [FUNCT_W-1:0] F_NOR   = FUNCT_W'(6'b100111);
   localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(6'b101010);
   localparam logic [FUNCT_W-1:0] F_XOR   = FUNCT_W'(6'b100110);
   localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(6'b011000);
   localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011001);
   localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'(6'b011010);
   localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'b011011);
   localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(6'b010000);
   localparam logic [FUNCT_W-1:0] F_MTHI  = FUNCT_W'(6'b010001);
   localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(6'b010010);
   localparam logic [FUNCT_W-1:0] F_MTLO  = FUNCT_W'(6'b010011);

   // Only the 6-bit MIPS funct field is supported.
   if (FUNCT_W != 6) begin : g_bad_funct_w
      $error("alu_ctrl_muldiv: FUNCT_W must be 6");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic                 is_div;
   logic                 neg_q;      // product / quotient negates
   logic                 neg_r;      // remainder negates
   logic                 div_zero;
   logic [WIDTH-1:0]     orig_a;
   logic [WIDTH-1:0]     shreg;      // multiplier (mul) / dividend->quotient (div)
   logic [WIDTH-1:0]     divisor;
   logic [2*WIDTH-1:0]   mcand;      // shifted multiplicand
   logic [2*WIDTH-1:0]   acc;        // product (mul) / remainder in low half (div)

   logic                 r_type, is_arith, is_mfhi, is_mflo, is_mthi, is_mtlo;
   logic                 op_signed, op_div, start;
   logic [WIDTH-1:0]     abs_a, abs_b;
   logic [WIDTH:0]       rem_sh;
   logic                 rem_ge;
   logic [WIDTH-1:0]     rem_sub, quo_fin, rem_fin;
   logic [2*WIDTH-1:0]   prod_fin;

   // Instruction decode for the MD unit.
   always_comb begin
      r_type    = (alu_op == 2'b10);
      is_arith  = r_type && (funct == F_MULT || funct == F_MULTU ||
                             funct == F_DIV  || funct == F_DIVU);
      is_mfhi   = r_type && (funct == F_MFHI);
      is_mflo   = r_type && (funct == F_MFLO);
      is_mthi   = r_type && (funct == F_MTHI);
      is_mtlo   = r_type && (funct == F_MTLO);
      op_signed = (funct == F_MULT) || (funct == F_DIV);
      op_div    = (funct == F_DIV)  || (funct == F_DIVU);
      start     = ex_fire && !md_busy && is_arith;
      abs_a     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
      abs_b     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;
   end

   // ALU control code; MD ops and unknown funct pass through as 0011.
   always_comb begin
      alu_ctl = 4'b0011;
      case (alu_op)
         2'b00: alu_ctl = 4'b0010;
         2'b10: begin
            case (funct)
               F_ADD:   alu_ctl = 4'b0010;
               F_SUB:   alu_ctl = 4'b0110;
               F_AND:   alu_ctl = 4'b0000;
               F_OR:    alu_ctl = 4'b0001;
               F_NOR:   alu_ctl = 4'b1100;
               F_SLT:   alu_ctl = 4'b0111;
               F_XOR:   alu_ctl = 4'b1111;
               default: alu_ctl = 4'b0011;
            endcase
         end
         default: alu_ctl = 4'b0011;
      endcase
   end

   // Hazard and writeback-select outputs.
   always_comb begin
      md_busy   = (state != S_IDLE);
      md_stall  = md_busy && (is_arith || is_mfhi || is_mflo || is_mthi || is_mtlo);
      md_sel    = is_mfhi || is_mflo;
      md_result = is_mfhi ? hi : (is_mflo ? lo : '0);
   end

   // Restoring-divide step and final sign correction.
   always_comb begin
      rem_sh   = {acc[WIDTH-1:0], shreg[WIDTH-1]};
      rem_ge   = (rem_sh >= {1'b0, divisor});
      rem_sub  = rem_sh[WIDTH-1:0] - divisor;
      prod_fin = neg_q ? -acc : acc;
      quo_fin  = neg_q ? -shreg : shreg;
      rem_fin  = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   end

   // MD sequencer: IDLE -> RUN (WIDTH steps) -> FIX -> IDLE; also mthi/mtlo.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         orig_a   <= '0;
         shreg    <= '0;
         divisor  <= '0;
         mcand    <= '0;
         acc      <= '0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_RUN;
                  cnt      <= '0;
                  is_div   <= op_div;
                  neg_q    <= op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  neg_r    <= op_signed && src_a[WIDTH-1];
                  div_zero <= (src_b == '0);
                  orig_a   <= src_a;
                  shreg    <= op_div ? abs_a : abs_b;
                  divisor  <= abs_b;
                  mcand    <= {WIDTH'(0), abs_a};
                  acc      <= '0;
               end else if (ex_fire && is_mthi) begin
                  hi <= src_a;
               end else if (ex_fire && is_mtlo) begin
                  lo <= src_a;
               end
            end
            S_RUN: begin
               if (is_div) begin
                  acc[WIDTH-1:0] <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                  shreg          <= {shreg[WIDTH-2:0], rem_ge};
               end else begin
                  if (shreg[0]) acc <= acc + mcand;
                  mcand <= mcand << 1;
                  shreg <= shreg >> 1;
               end
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
            end
            S_FIX: begin
               if (!is_div) begin
                  hi <= prod_fin[2*WIDTH-1:WIDTH];
                  lo <= prod_fin[WIDTH-1:0];
               end else if (div_zero) begin
                  hi <= orig_a;
                  lo <= '1;
               end else begin
                  hi <= rem_fin;
                  lo <= quo_fin;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed bench for alu_ctrl_muldiv with a HI/LO scoreboard.
module tb_alu_ctrl_muldiv;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic        ex_fire;
   logic [31:0] src_a, src_b;
   logic [3:0]  alu_ctl;
   logic        md_busy, md_stall, md_sel;
   logic [31:0] md_result, hi, lo;

   typedef struct {
      string       tag;
      logic [63:0] hl;
   } exp_t;
   exp_t sb[$];

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   logic [5:0] f_tab [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                             6'b100111, 6'b101010, 6'b100110, 6'b000000};
   logic [3:0] c_tab [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                             4'b1100, 4'b0111, 4'b1111, 4'b0011};

   alu_ctrl_muldiv #(.WIDTH(32), .FUNCT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct(funct), .ex_fire(ex_fire),
      .src_a(src_a), .src_b(src_b), .alu_ctl(alu_ctl), .md_busy(md_busy),
      .md_stall(md_stall), .md_sel(md_sel), .md_result(md_result), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_chk++;
      assert (obs === exp_v) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic fire,
                        input logic [31:0] a, input logic [31:0] b);
      alu_op = op; funct = f; ex_fire = fire; src_a = a; src_b = b;
      #1;
   endtask

   // Present an MD op for one start edge, then return EX to a plain add.
   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      drive(2'b10, f, 1'b1, a, b);
      tick();
      drive(2'b00, F_ADD, 1'b0, '0, '0);
   endtask

   task automatic push(input string tag, input logic [63:0] hl);
      sb.push_back('{tag, hl});
   endtask

   // Count busy cycles (bounded), then compare HI/LO against the scoreboard head.
   task automatic wait_done(input int exp_busy);
      int   n;
      exp_t e;
      n = 0;
      while (md_busy === 1'b1 && n < 200) begin
         n++;
         tick();
      end
      if (sb.size() == 0) begin
         check("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
         check({e.tag, "_busy_len"}, 64'(n), 64'(exp_busy));
         check({e.tag, "_hi"}, 64'(hi), 64'(e.hl[63:32]));
         check({e.tag, "_lo"}, 64'(lo), 64'(e.hl[31:0]));
      end
   endtask

   initial begin
      int          n;
      logic [31:0] ra, rb;
      longint      sa, sbv;

      rst_n = 1'b0;
      drive(2'b00, F_ADD, 1'b0, '0, '0);
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_busy", 64'(md_busy), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_md_result", 64'(md_result), 64'd0);

      // ALU control decode
      for (int i = 0; i < 8; i++) begin
         drive(2'b10, f_tab[i], 1'b0, '0, '0);
         check($sformatf("alu_ctl_f%02h", f_tab[i]), 64'(alu_ctl), 64'(c_tab[i]));
      end
      drive(2'b00, 6'b100010, 1'b0, '0, '0);
      check("alu_ctl_op00", 64'(alu_ctl), 64'h2);
      drive(2'b01, 6'b100000, 1'b0, '0, '0);
      check("alu_ctl_op01", 64'(alu_ctl), 64'h3);
      drive(2'b11, 6'b100000, 1'b0, '0, '0);
      check("alu_ctl_op11", 64'(alu_ctl), 64'h3);
      drive(2'b10, F_MULT, 1'b0, '0, '0);
      check("alu_ctl_mult", 64'(alu_ctl), 64'h3);
      drive(2'b00, F_ADD, 1'b0, '0, '0);

      // Directed multiply / divide results
      push("mult_m2x3", 64'hFFFFFFFF_FFFFFFFA);
      issue(F_MULT, 32'hFFFFFFFE, 32'd3);
      wait_done(33);
      push("multu_m2x3", 64'h00000002_FFFFFFFA);
      issue(F_MULTU, 32'hFFFFFFFE, 32'd3);
      wait_done(33);
      push("div_m7d2", 64'hFFFFFFFF_FFFFFFFD);
      issue(F_DIV, 32'hFFFFFFF9, 32'd2);
      wait_done(33);
      push("divu_100d0", 64'h00000064_FFFFFFFF);
      issue(F_DIVU, 32'd100, 32'd0);
      wait_done(33);
      push("div_min_m1", 64'h00000000_80000000);
      issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_done(33);

      // mthi / mtlo while idle
      drive(2'b10, F_MTHI, 1'b1, 32'h1234, 32'h0);
      tick();
      drive(2'b00, F_ADD, 1'b0, '0, '0);
      check("mthi_hi", 64'(hi), 64'h1234);
      check("mthi_lo_kept", 64'(lo), 64'h80000000);
      drive(2'b10, F_MTLO, 1'b1, 32'h5678, 32'h0);
      tick();
      drive(2'b00, F_ADD, 1'b0, '0, '0);
      check("mtlo_lo", 64'(lo), 64'h5678);

      // mfhi enters EX one cycle after the mult start edge
      push("mult_mfhi", 64'h00000002_00000008);
      issue(F_MULT, 32'h40000001, 32'd8);
      tick();
      drive(2'b10, F_MFHI, 1'b0, '0, '0);
      check("mfhi_sel_busy", 64'(md_sel), 64'd1);
      n = 0;
      while (md_stall === 1'b1 && n < 200) begin
         n++;
         tick();
      end
      check("mfhi_stall_len", 64'(n), 64'd32);
      check("mfhi_busy_after", 64'(md_busy), 64'd0);
      check("mfhi_result", 64'(md_result), 64'h2);
      check("mfhi_sel", 64'(md_sel), 64'd1);
      drive(2'b10, F_MFLO, 1'b0, '0, '0);
      check("mflo_result", 64'(md_result), 64'h8);
      drive(2'b00, F_ADD, 1'b0, '0, '0);
      wait_done(0);

      // Second mult held in EX while the first is busy
      push("multu_first", 64'h00000000_0000003F);
      push("mult_second", 64'hFFFFFFFF_FFFFFFFB);
      issue(F_MULTU, 32'd7, 32'd9);
      drive(2'b10, F_MULT, 1'b1, 32'hFFFFFFFF, 32'd5);
      n = 0;
      while (md_busy === 1'b1 && n < 200) begin
         if (n == 5) begin
            check("second_stalled", 64'(md_stall), 64'd1);
            check("hi_held_run", 64'(hi), 64'h2);
         end
         if (n == 10) begin
            drive(2'b00, F_ADD, 1'b0, '0, '0);
            check("add_no_stall", 64'(md_stall), 64'd0);
            check("add_ctl_busy", 64'(alu_ctl), 64'h2);
            check("add_sel", 64'(md_sel), 64'd0);
            drive(2'b10, F_MULT, 1'b1, 32'hFFFFFFFF, 32'd5);
         end
         n++;
         tick();
      end
      wait_done(33 - n);
      check("first_busy_len", 64'(n), 64'd33);
      tick();
      drive(2'b00, F_ADD, 1'b0, '0, '0);
      wait_done(33);

      // Reset mid-operation discards the result
      issue(F_MULT, 32'd3, 32'd4);
      repeat (10) tick();
      check("pre_rst_busy", 64'(md_busy), 64'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_busy", 64'(md_busy), 64'd0);
      check("midrst_hi", 64'(hi), 64'd0);
      check("midrst_lo", 64'(lo), 64'd0);
      push("mult_after_rst", 64'hFFFFFFFF_FFFFFFF4);
      issue(F_MULT, 32'd3, 32'hFFFFFFFC);
      wait_done(33);

      // Random operands against a behavioural model
      for (int i = 0; i < 3; i++) begin
         ra = $urandom;
         rb = 32'($urandom_range(1, 100000));
         if (i == 1) rb = -rb;
         sa  = longint'(signed'(ra));
         sbv = longint'(signed'(rb));
         push($sformatf("rnd_multu%0d", i), 64'(ra) * 64'(rb));
         issue(F_MULTU, ra, rb);
         wait_done(33);
         push($sformatf("rnd_mult%0d", i), 64'(sa * sbv));
         issue(F_MULT, ra, rb);
         wait_done(33);
         push($sformatf("rnd_divu%0d", i), {ra % rb, ra / rb});
         issue(F_DIVU, ra, rb);
         wait_done(33);
         push($sformatf("rnd_div%0d", i), {32'(sa % sbv), 32'(sa / sbv)});
         issue(F_DIV, ra, rb);
         wait_done(33);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
